// File: rtl/sequence_gen_if.sv
// Control/data bundle for the serial pattern transmitter: request side
// (start/abort/pattern fields) and serial/handshake outputs.
interface sequence_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] repeat_cnt;
  logic             data_out;
  logic             data_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, pat_len, repeat_cnt,
    input  data_out, data_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, pat_len, repeat_cnt,
    output data_out, data_valid, busy, done
  );
endinterface

// File: rtl/sequence_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first of its
// active field, repeated back-to-back, with start/busy/done and abort.
module sequence_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       resetn,
  sequence_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_nstate;
  logic [PAT_W-1:0] r_pat,   w_npat;
  logic [LEN_W-1:0] r_len,   w_nlen;
  logic [LEN_W-1:0] r_bit,   w_nbit;
  logic [CNT_W-1:0] r_rep,   w_nrep;
  logic             r_data,  w_ndata;
  logic             r_valid, w_nvalid;
  logic             r_busy,  w_nbusy;
  logic             r_done,  w_ndone;

  logic [LEN_W-1:0] w_eff_len, w_eff_len_m1;
  logic [CNT_W-1:0] w_eff_rep_m1;
  logic             w_start_bit, w_next_bit, w_reload_bit;

  // Oversize and zero lengths clamp to the full width; zero repeats means one.
  assign w_eff_len    = ((bus.pat_len == '0) || (bus.pat_len > LEN_W'(PAT_W)))
                        ? LEN_W'(PAT_W) : bus.pat_len;
  assign w_eff_len_m1 = w_eff_len - LEN_W'(1);
  assign w_eff_rep_m1 = (bus.repeat_cnt == '0) ? '0 : bus.repeat_cnt - CNT_W'(1);

  // Bit selects done as mask-and-reduce so every pattern bit is consumed.
  assign w_start_bit  = |(bus.pattern & (PAT_W'(1) << w_eff_len_m1));
  assign w_next_bit   = |(r_pat & (PAT_W'(1) << (r_bit - LEN_W'(1))));
  assign w_reload_bit = |(r_pat & (PAT_W'(1) << (r_len - LEN_W'(1))));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_bit   <= '0;
      r_rep   <= '0;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pat   <= w_npat;
      r_len   <= w_nlen;
      r_bit   <= w_nbit;
      r_rep   <= w_nrep;
      r_data  <= w_ndata;
      r_valid <= w_nvalid;
      r_busy  <= w_nbusy;
      r_done  <= w_ndone;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_npat   = r_pat;
    w_nlen   = r_len;
    w_nbit   = r_bit;
    w_nrep   = r_rep;
    w_ndata  = r_data;
    w_nvalid = r_valid;
    w_nbusy  = r_busy;
    w_ndone  = r_done;

    unique case (r_state)
      ST_IDLE: begin
        w_ndata  = 1'b0;
        w_nvalid = 1'b0;
        w_nbusy  = 1'b0;
        w_ndone  = 1'b0;
        if (bus.start && !bus.abort) begin
          w_npat   = bus.pattern;
          w_nlen   = w_eff_len;
          w_nbit   = w_eff_len_m1;
          w_nrep   = w_eff_rep_m1;
          w_ndata  = w_start_bit;
          w_nvalid = 1'b1;
          w_nbusy  = 1'b1;
          w_nstate = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (bus.abort) begin
          w_nstate = ST_IDLE;
          w_ndata  = 1'b0;
          w_nvalid = 1'b0;
          w_nbusy  = 1'b0;
          w_ndone  = 1'b0;
        end else if (r_bit != '0) begin
          w_nbit  = r_bit - LEN_W'(1);
          w_ndata = w_next_bit;
        end else if (r_rep != '0) begin
          // Reload without a bubble so repetitions stay contiguous.
          w_nbit  = r_len - LEN_W'(1);
          w_nrep  = r_rep - CNT_W'(1);
          w_ndata = w_reload_bit;
        end else begin
          w_nstate = ST_DONE;
          w_ndata  = 1'b0;
          w_nvalid = 1'b0;
          w_ndone  = 1'b1;
        end
      end

      ST_DONE: begin
        w_nstate = ST_IDLE;
        w_ndata  = 1'b0;
        w_nvalid = 1'b0;
        w_nbusy  = 1'b0;
        w_ndone  = 1'b0;
      end

      default: begin
        w_nstate = ST_IDLE;
        w_ndata  = 1'b0;
        w_nvalid = 1'b0;
        w_nbusy  = 1'b0;
        w_ndone  = 1'b0;
      end
    endcase
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_sequence_gen.sv
// Directed bench for sequence_gen: framing, repeats, length clamps, ignored
// starts, abort and asynchronous reset.
module tb_sequence_gen;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sequence_gen_if #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) u_if ();

  sequence_gen #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) u_dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic d, input logic v,
                         input logic b, input logic dn);
    chk({tag, ".data_out"},   32'(u_if.data_out),   32'(d));
    chk({tag, ".data_valid"}, 32'(u_if.data_valid), 32'(v));
    chk({tag, ".busy"},       32'(u_if.busy),       32'(b));
    chk({tag, ".done"},       32'(u_if.done),       32'(dn));
  endtask

  // Raise start for one edge; returns at the negedge showing the first bit.
  task automatic kick(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
    u_if.pattern    = pat;
    u_if.pat_len    = len;
    u_if.repeat_cnt = rep;
    u_if.start      = 1'b1;
    @(negedge clk);
    u_if.start      = 1'b0;
  endtask

  // Checks n valid bits (bits[n-1] first), the done cycle, then first IDLE cycle.
  // poke_at = cycle index at which a spurious start with new inputs is pulsed.
  task automatic expect_stream(input string tag, input logic [31:0] bits,
                               input int n, input int poke_at);
    logic [31:0] b;
    b = bits;
    for (int i = 0; i <= n; i++) begin
      if (i < n) chk_out($sformatf("%s.bit%0d", tag, i), b[n-1-i], 1'b1, 1'b1, 1'b0);
      else       chk_out($sformatf("%s.done", tag), 1'b0, 1'b0, 1'b1, 1'b1);
      if (i == poke_at) begin
        u_if.start      = 1'b1;
        u_if.pattern    = 8'hFF;
        u_if.pat_len    = 4'd2;
        u_if.repeat_cnt = 4'd5;
      end
      @(negedge clk);
      u_if.start = 1'b0;
    end
    chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n           = 1'b0;
    u_if.start      = 1'b0;
    u_if.abort      = 1'b0;
    u_if.pattern    = '0;
    u_if.pat_len    = '0;
    u_if.repeat_cnt = '0;

    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Single 4-bit frame 1011
    kick(8'h0B, 4'd4, 4'd1);
    expect_stream("f1011", 32'b1011, 4, -1);

    // Three back-to-back repetitions, no gaps
    kick(8'h0B, 4'd4, 4'd3);
    expect_stream("rep3", 32'b1011_1011_1011, 12, -1);

    // Length clamps: 0 and 9 both mean 8; repeat 0 means 1
    kick(8'hA5, 4'd0, 4'd0);
    expect_stream("len0", 32'hA5, 8, -1);
    kick(8'hA5, 4'd9, 4'd0);
    expect_stream("len9", 32'hA5, 8, -1);
    kick(8'hA5, 4'd15, 4'd1);
    expect_stream("len15", 32'hA5, 8, -1);

    // Spurious start during SHIFT is ignored
    kick(8'h0B, 4'd4, 4'd1);
    expect_stream("poke_shift", 32'b1011, 4, 1);
    @(negedge clk);
    chk_out("poke_shift.still_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Spurious start during DONE is ignored
    kick(8'h0B, 4'd4, 4'd1);
    expect_stream("poke_done", 32'b1011, 4, 4);
    @(negedge clk);
    chk_out("poke_done.still_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Earliest restart: start in first IDLE cycle after done
    kick(8'h06, 4'd3, 4'd1);
    expect_stream("b110", 32'b110, 3, -1);
    kick(8'h01, 4'd2, 4'd2);
    expect_stream("restart01", 32'b0101, 4, -1);

    // Abort on the third valid bit of an 8-bit frame
    kick(8'hA5, 4'd8, 4'd1);
    chk_out("abort.bit0", 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("abort.bit1", 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("abort.bit2", 1'b1, 1'b1, 1'b1, 1'b0);
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    chk_out("abort.next", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_out($sformatf("abort.quiet%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Abort together with start in IDLE: nothing starts
    u_if.pattern    = 8'hFF;
    u_if.pat_len    = 4'd4;
    u_if.repeat_cnt = 4'd1;
    u_if.abort      = 1'b1;
    u_if.start      = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    u_if.start = 1'b0;
    chk_out("abort_start.c0", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("abort_start.c1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-SHIFT, between clock edges
    kick(8'hFF, 4'd8, 4'd2);
    @(negedge clk);
    chk_out("areset.pre", 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("areset.now", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out($sformatf("areset.idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    kick(8'h0B, 4'd4, 4'd1);
    expect_stream("after_reset", 32'b1011, 4, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
